// File: rtl/sccb_write_arbiter.sv
// sccb_write_arbiter: round-robin sharing of one SCCB master among NREQ register writers.
// Optional macro SCCB_RETRY_EN enables automatic retry of NACKed writes. Rev 1.0
`default_nettype none

module sccb_write_arbiter #(
  parameter int         NREQ       = 2,
  parameter logic [7:0] SLAVE_ADDR = 8'h42,
  parameter int         GAP_CYCLES = 65536,
  parameter int         GAP_W      = 17,
  parameter int         MAX_RETRY  = 3
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic              busy,
  output logic              i2c_start,
  output logic              i2c_stop,
  output logic [7:0]        i2c_wr_data,
  input  logic [1:0]        i2c_ack,
  input  logic [3:0]        i2c_state
);

  localparam int               IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_W_SLV = 3'd2,
    S_W_REG = 3'd3,
    S_W_DAT = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, grant, pick_idx, cand;
  logic             pick_found;
  logic [7:0]       lat_addr, lat_data;
  logic [GAP_W-1:0] gap_cnt;
  logic             load_grant, gap_inc, gap_clr;
  logic             done_hit, err_hit;
  logic             ack_tick, nack_tick, in_write;
  logic             nack_final, retry_go;

  assign ack_tick  = (i2c_ack == 2'b11);
  assign nack_tick = (i2c_ack == 2'b10);
  assign in_write  = (state == S_W_SLV) || (state == S_W_REG) || (state == S_W_DAT);
  assign busy      = (state != S_IDLE);

`ifdef SCCB_RETRY_EN
  localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [RC_W-1:0] retry_cnt;
  logic            retry_pend;
  logic            retry_arm;

  assign nack_final = (retry_cnt == RC_W'(MAX_RETRY));
  assign retry_arm  = in_write && nack_tick && !nack_final;
  assign retry_go   = retry_pend;

  // A pending retry bypasses arbitration and reuses the latched grant and operands.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
    end else if (load_grant) begin
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
    end else if (retry_arm) begin
      retry_cnt  <= retry_cnt + 1'b1;
      retry_pend <= 1'b1;
    end else if (gap_clr) begin
      retry_pend <= 1'b0;
    end
  end
`else
  assign nack_final = 1'b1;
  assign retry_go   = 1'b0;
`endif

  // Lowest rotation offset from ptr wins; scanning downward lets it overwrite.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    i2c_start   = 1'b0;
    i2c_stop    = 1'b0;
    i2c_wr_data = 8'h00;
    done_hit    = 1'b0;
    err_hit     = 1'b0;
    load_grant  = 1'b0;
    gap_inc     = 1'b0;
    gap_clr     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pick_found) begin
          load_grant = 1'b1;
          state_nxt  = S_START;
        end
      end
      S_START: begin
        i2c_start   = 1'b1;
        i2c_wr_data = SLAVE_ADDR;
        state_nxt   = S_W_SLV;
      end
      S_W_SLV, S_W_REG, S_W_DAT: begin
        if (ack_tick) begin
          if (state == S_W_SLV) begin
            i2c_wr_data = lat_addr;
            state_nxt   = S_W_REG;
          end else if (state == S_W_REG) begin
            i2c_wr_data = lat_data;
            state_nxt   = S_W_DAT;
          end else begin
            i2c_stop  = 1'b1;
            done_hit  = 1'b1;
            state_nxt = S_GAP;
          end
        end else if (nack_tick) begin
          i2c_stop  = 1'b1;
          done_hit  = nack_final;
          err_hit   = nack_final;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        // The idle gap only counts once the master itself is idle.
        if (i2c_state == 4'd0) begin
          if (gap_cnt == GAP_END) begin
            gap_clr   = 1'b1;
            state_nxt = retry_go ? S_START : S_IDLE;
          end else begin
            gap_inc = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    done = '0;
    err  = '0;
    if (done_hit) done[grant] = 1'b1;
    if (err_hit)  err[grant]  = 1'b1;
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      ptr      <= '0;
      grant    <= '0;
      lat_addr <= 8'h00;
      lat_data <= 8'h00;
      gap_cnt  <= '0;
    end else begin
      if (load_grant) begin
        grant    <= pick_idx;
        ptr      <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
        lat_addr <= req_addr[8*pick_idx +: 8];
        lat_data <= req_data[8*pick_idx +: 8];
      end
      if (gap_clr) begin
        gap_cnt <= '0;
      end else if (gap_inc) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sccb_write_arbiter.sv
// tb_sccb_write_arbiter: randomized bench with an SCCB master model and a round-robin reference.
`default_nettype none

module tb_sccb_write_arbiter;

  localparam int N         = 3;
  localparam int GAP       = 20;
  localparam int MAX_RETRY = 3;
`ifdef SCCB_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_addr, req_data;
  logic [N-1:0]   done, err;
  logic           busy, i2c_start, i2c_stop;
  logic [7:0]     i2c_wr_data;
  logic [1:0]     i2c_ack;
  logic [3:0]     i2c_state;

  int errors = 0;
  int checks = 0;

  int         m_ptr, m_g, m_att;
  bit         m_retry_pend;
  logic [7:0] m_addr, m_data;

  sccb_write_arbiter #(
    .NREQ(N), .SLAVE_ADDR(8'h42), .GAP_CYCLES(GAP), .GAP_W(17), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk_100MHz (clk),
    .rst        (rst),
    .req        (req),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .done       (done),
    .err        (err),
    .busy       (busy),
    .i2c_start  (i2c_start),
    .i2c_stop   (i2c_stop),
    .i2c_wr_data(i2c_wr_data),
    .i2c_ack    (i2c_ack),
    .i2c_state  (i2c_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbiter: first requesting index at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  task automatic reset_model();
    m_ptr        = 0;
    m_att        = 0;
    m_retry_pend = 1'b0;
  endtask

  task automatic wait_start(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!i2c_start && n < limit);
    if (!i2c_start) check("start_timeout", 0, 1);
  endtask

  task automatic do_reset();
    i2c_ack = 2'b00;
    rst     = 1'b1;
    tick();
    check("reset_outputs", {busy, i2c_start, i2c_stop, done, err, i2c_wr_data}, 0);
    rst       = 1'b0;
    i2c_state = 4'd0;
    reset_model();
  endtask

  // Serves one attempt starting in the cycle i2c_start was seen, then runs the gap.
  // rmode: 0 random request update, 1 keep requests, 2 clear granted request.
  task automatic do_attempt(input bit nack, input int nph, input int hold, input int rmode);
    bit fin;
    int n, exp_lat;
    logic [31:0] exp_done;
    check("start_byte", i2c_wr_data, 8'h42);
    check("busy_start", busy, 1);
    if (!m_retry_pend) begin
      m_g    = rr_pick(req, m_ptr);
      m_ptr  = (m_g + 1) % N;
      m_addr = req_addr[8*m_g +: 8];
      m_data = req_data[8*m_g +: 8];
      m_att  = 0;
      req_addr = (8*N)'($urandom);
      req_data = (8*N)'($urandom);
    end
    m_retry_pend = 1'b0;
    i2c_state = 4'd3;
    tick();
    fin = 1'b1;
    for (int ph = 0; ph < 3; ph++) begin
      repeat ($urandom_range(0, 2)) begin
        i2c_ack = $urandom_range(0, 1) ? 2'b01 : 2'b00;
        #1;
        check("quiet", {i2c_start, i2c_stop, done, err, i2c_wr_data}, 0);
        tick();
      end
      if (nack && ph == nph) begin
        i2c_ack = 2'b10;
        #1;
        fin      = !RETRY || (m_att == MAX_RETRY);
        exp_done = fin ? (32'd1 << m_g) : 32'd0;
        check("nack_stop", i2c_stop, 1);
        check("nack_done", done, exp_done);
        check("nack_err", err, exp_done);
        check("nack_wr", i2c_wr_data, 0);
        tick();
        i2c_ack = 2'b00;
        break;
      end
      i2c_ack = 2'b11;
      #1;
      if (ph == 0) begin
        check("addr_byte", i2c_wr_data, m_addr);
        check("addr_nostop", {i2c_stop, done, err}, 0);
      end else if (ph == 1) begin
        check("data_byte", i2c_wr_data, m_data);
        check("data_nostop", {i2c_stop, done, err}, 0);
      end else begin
        check("final_stop", i2c_stop, 1);
        check("final_done", done, 32'd1 << m_g);
        check("final_err", err, 0);
      end
      tick();
      i2c_ack = 2'b00;
    end
    if (fin) begin
      m_att = 0;
      case (rmode)
        0: begin
          if ($urandom_range(0, 1) == 1) req[m_g] = 1'b0;
          req = req | (N'($urandom) & N'($urandom));
          if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
        end
        2: req[m_g] = 1'b0;
        default: ;
      endcase
    end else begin
      m_att++;
      m_retry_pend = 1'b1;
    end
    repeat (hold) tick();
    check("busy_gap", busy, 1);
    i2c_state = 4'd0;
    if (!fin) exp_lat = GAP + 1;
    else if (req != '0) exp_lat = GAP + 2;
    else exp_lat = 0;
    if (exp_lat > 0) begin
      wait_start(GAP + 10, n);
      check("gap_latency", n, exp_lat);
    end else begin
      repeat (GAP + 1) tick();
      check("busy_idle", busy, 0);
    end
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    req       = '0;
    i2c_ack   = 2'b00;
    i2c_state = 4'd0;
    req_addr  = (8*N)'($urandom);
    req_data  = (8*N)'($urandom);
    repeat (3) tick();
    check("reset_outputs", {busy, i2c_start, i2c_stop, done, err, i2c_wr_data}, 0);
    rst = 1'b0;
    reset_model();

    // Single write from requester 0.
    req_addr[7:0] = 8'h12;
    req_data[7:0] = 8'h80;
    req           = 3'b001;
    wait_start(4, n);
    check("grant_latency", n, 1);
    do_attempt(1'b0, 0, 2, 2);

    // Contention after reset: 0 first, then alternation with req held.
    do_reset();
    req = 3'b011;
    wait_start(4, n);
    check("grant_latency2", n, 1);
    do_attempt(1'b0, 0, 1, 1);
    do_attempt(1'b0, 0, 50, 1);
    do_attempt(1'b0, 0, 0, 1);
    do_attempt(1'b0, 0, 3, 1);

    // NACK on the register-address byte.
    do_attempt(1'b1, 1, 0, 1);

    // Two NACKs then success; then four NACKs in a row.
    do_attempt(1'b1, 0, 0, 1);
    do_attempt(1'b1, 2, 1, 1);
    do_attempt(1'b0, 0, 0, 1);
    for (int i = 0; i < 4; i++) do_attempt(1'b1, 2, 0, 1);

    for (int i = 0; i < 40; i++) begin
      do_attempt($urandom_range(0, 3) == 0, $urandom_range(0, 2), $urandom_range(0, 4), 0);
    end

    // Reset while waiting in the register-address phase.
    i2c_state = 4'd3;
    tick();
    i2c_ack = 2'b11;
    tick();
    i2c_ack = 2'b00;
    do_reset();
    req = 3'b010;
    wait_start(2, n);
    check("rst_restart", i2c_start, 1);
    do_attempt(1'b0, 0, 0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
